// File: rtl/dl_frame_serializer.sv
// dl_frame_serializer
// Collects the payload-cluster and header-cluster encoding results from the
// FEC engine, then streams one fixed 14-byte frame into the UART TX FIFO over
// a valid/ready byte interface.
//
// Frame layout (idx 0..13):
//   0      SYNC_BYTE
//   1      {msg_tag, crc1}
//   2      msg_len
//   3      {enc1_row_p, enc1_col_p}
//   4..10  payload bytes D0..D6
//   11     crc0
//   12     enc0_row_p
//   13     enc0_col_p
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   data_in, msg_len, msg_tag       raw payload and header fields
//   enc0_done, crc0_data, enc0_*    payload cluster result strobe + values
//   enc1_done, crc1_data, enc1_*    header cluster result strobe + values
//   tx_data, tx_valid, tx_ready     registered byte stream to the TX FIFO
//   busy                            capture or transmission in progress
//   frame_done                      pulse the cycle after the last byte is taken
//   ovr_err                         pulse after a done strobe that arrived too late
module dl_frame_serializer #(
  parameter logic [7:0] SYNC_BYTE      = 8'h7E,
  parameter int         NUM_DATA_BYTES = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [8*NUM_DATA_BYTES-1:0] data_in,
  input  logic [7:0]                  msg_len,
  input  logic [3:0]                  msg_tag,
  input  logic                        enc0_done,
  input  logic [7:0]                  crc0_data,
  input  logic [7:0]                  enc0_row_p,
  input  logic [7:0]                  enc0_col_p,
  input  logic                        enc1_done,
  input  logic [3:0]                  crc1_data,
  input  logic [3:0]                  enc1_row_p,
  input  logic [3:0]                  enc1_col_p,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        ovr_err
);

  localparam int FRAME_LEN = NUM_DATA_BYTES + 7;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t state_r;
  state_t next_state_s;

  logic [8*NUM_DATA_BYTES-1:0] data_r;
  logic [7:0]       len_r;
  logic [3:0]       tag_r;
  logic [7:0]       crc0_r, row0_r, col0_r;
  logic [3:0]       crc1_r, row1_r, col1_r;
  logic             f0_r, f1_r;
  logic [IDX_W-1:0] idx_r;
  logic [7:0]       tx_data_r;
  logic             tx_valid_r, busy_r, frame_done_r, ovr_err_r;

  logic capture_en_s, start_s, accept_s, last_s, any_done_s;

  // Byte idx of the frame, assembled from the captured registers.
  function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] i);
    int k;
    logic [7:0] b;
    k = int'(i);
    b = 8'h00;
    if (k == 0)                        b = SYNC_BYTE;
    else if (k == 1)                   b = {tag_r, crc1_r};
    else if (k == 2)                   b = len_r;
    else if (k == 3)                   b = {row1_r, col1_r};
    else if (k < 4 + NUM_DATA_BYTES)   b = data_r[8*(k-4) +: 8];
    else if (k == 4 + NUM_DATA_BYTES)  b = crc0_r;
    else if (k == 5 + NUM_DATA_BYTES)  b = row0_r;
    else if (k == 6 + NUM_DATA_BYTES)  b = col0_r;
    else                               b = 8'h00;
    return b;
  endfunction

  // Results are only accepted before transmission starts; the frame contents
  // are frozen once SEND begins.
  assign capture_en_s = (state_r == ST_IDLE) || (state_r == ST_WAIT);
  assign any_done_s   = enc0_done || enc1_done;
  assign start_s      = (state_r == ST_WAIT) && f0_r && f1_r;
  assign accept_s     = (state_r == ST_SEND) && tx_valid_r && tx_ready;
  assign last_s       = (idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: if (any_done_s) next_state_s = ST_WAIT; else next_state_s = ST_IDLE;
      ST_WAIT: if (start_s)    next_state_s = ST_SEND; else next_state_s = ST_WAIT;
      ST_SEND: if (accept_s && last_s) next_state_s = ST_DONE; else next_state_s = ST_SEND;
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Cluster capture registers and completion flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= '0;      crc0_r <= 8'h00; row0_r <= 8'h00; col0_r <= 8'h00;
      len_r  <= 8'h00;   tag_r  <= 4'h0;  crc1_r <= 4'h0;  row1_r <= 4'h0;
      col1_r <= 4'h0;    f0_r   <= 1'b0;  f1_r   <= 1'b0;
    end else begin
      if (capture_en_s && enc0_done) begin
        data_r <= data_in;
        crc0_r <= crc0_data;
        row0_r <= enc0_row_p;
        col0_r <= enc0_col_p;
      end
      if (capture_en_s && enc1_done) begin
        len_r  <= msg_len;
        tag_r  <= msg_tag;
        crc1_r <= crc1_data;
        row1_r <= enc1_row_p;
        col1_r <= enc1_col_p;
      end
      if (state_r == ST_DONE) begin
        f0_r <= 1'b0;
        f1_r <= 1'b0;
      end else begin
        f0_r <= f0_r || (capture_en_s && enc0_done);
        f1_r <= f1_r || (capture_en_s && enc1_done);
      end
    end
  end

  // Byte index and registered stream outputs. The next byte is looked up at
  // acceptance so that a new byte appears every cycle while tx_ready is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (start_s) begin
      idx_r      <= '0;
      tx_data_r  <= frame_byte('0);
      tx_valid_r <= 1'b1;
    end else if (accept_s && last_s) begin
      idx_r      <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
    end else if (accept_s) begin
      idx_r      <= idx_r + IDX_ONE;
      tx_data_r  <= frame_byte(idx_r + IDX_ONE);
      tx_valid_r <= 1'b1;
    end else if (state_r == ST_DONE) begin
      idx_r      <= '0;
      tx_data_r  <= tx_data_r;
      tx_valid_r <= 1'b0;
    end else begin
      idx_r      <= idx_r;
      tx_data_r  <= tx_data_r;
      tx_valid_r <= tx_valid_r;
    end
  end

  // Status pulses and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      ovr_err_r    <= 1'b0;
    end else begin
      busy_r       <= (next_state_s != ST_IDLE);
      frame_done_r <= accept_s && last_s;
      ovr_err_r    <= any_done_s && ((state_r == ST_SEND) || (state_r == ST_DONE));
    end
  end

  assign tx_data    = tx_data_r;
  assign tx_valid   = tx_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign ovr_err    = ovr_err_r;

endmodule

// File: tb/tb_dl_frame_serializer.sv
// Testbench for dl_frame_serializer: expected frames are pushed into a byte
// scoreboard when stimulus is issued; a negedge monitor pops and compares every
// accepted byte, checks hold-during-stall and frame_done timing.
module tb_dl_frame_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [55:0] data_in = '0;
  logic [7:0]  msg_len = 8'h00;
  logic [3:0]  msg_tag = 4'h0;
  logic        enc0_done = 1'b0;
  logic [7:0]  crc0_data = 8'h00, enc0_row_p = 8'h00, enc0_col_p = 8'h00;
  logic        enc1_done = 1'b0;
  logic [3:0]  crc1_data = 4'h0, enc1_row_p = 4'h0, enc1_col_p = 4'h0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy, frame_done, ovr_err;

  dl_frame_serializer dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .msg_len(msg_len), .msg_tag(msg_tag),
    .enc0_done(enc0_done), .crc0_data(crc0_data), .enc0_row_p(enc0_row_p), .enc0_col_p(enc0_col_p),
    .enc1_done(enc1_done), .crc1_data(crc1_data), .enc1_row_p(enc1_row_p), .enc1_col_p(enc1_col_p),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_done(frame_done), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [55:0] data;
    logic [7:0]  len;
    logic [3:0]  tag, crc1, row1, col1;
    logic [7:0]  crc0, row0, col0;
  } fields_t;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  int         sent_cnt = 0;
  bit         expect_fd = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         rmode = 0;
  int         pat_i = 0;
  int         stall_cnt = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference frame: sync, header fields, payload bytes low-first, payload code.
  function automatic void push_frame(fields_t f);
    sb.push_back(8'h7E);
    sb.push_back({f.tag, f.crc1});
    sb.push_back(f.len);
    sb.push_back({f.row1, f.col1});
    for (int k = 0; k < 7; k++) sb.push_back(f.data[8*k +: 8]);
    sb.push_back(f.crc0);
    sb.push_back(f.row0);
    sb.push_back(f.col0);
  endfunction

  function automatic fields_t rand_fields();
    fields_t f;
    f.data[31:0]  = $urandom;
    f.data[55:32] = 24'($urandom);
    f.len  = 8'($urandom);
    f.tag  = 4'($urandom);
    f.crc1 = 4'($urandom);
    f.row1 = 4'($urandom);
    f.col1 = 4'($urandom);
    f.crc0 = 8'($urandom);
    f.row0 = 8'($urandom);
    f.col0 = 8'($urandom);
    return f;
  endfunction

  // Monitor: scoreboard compare, stall stability and frame_done timing.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst_n) begin
      sb.delete();
      sent_cnt  = 0;
      expect_fd = 1'b0;
    end else begin
      if (expect_fd || frame_done) check("frame_done", 32'(frame_done), 32'(expect_fd));
      expect_fd = 1'b0;
      if (prev_stall) check("stall_hold", 32'({tx_valid, tx_data}), 32'({1'b1, prev_data}));
      if (tx_valid && tx_ready) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_data);
        end else begin
          exp_b = sb.pop_front();
          check($sformatf("byte%0d", sent_cnt), 32'(tx_data), 32'(exp_b));
        end
        sent_cnt++;
        if (sent_cnt == 14) begin
          sent_cnt  = 0;
          expect_fd = 1'b1;
        end
      end
    end
    prev_stall = rst_n && tx_valid && !tx_ready;
    prev_data  = tx_data;
  end

  // tx_ready generator: 0 always ready, 1 random, 2 pattern 1,0,0,1 plus a
  // 5-cycle stall while byte 6 is presented.
  always begin
    @(posedge clk);
    #1;
    case (rmode)
      1: tx_ready = 1'($urandom_range(0, 1));
      2: begin
        if (sent_cnt == 6 && stall_cnt < 5) begin
          tx_ready = 1'b0;
          stall_cnt++;
        end else begin
          tx_ready = (pat_i == 0) || (pat_i == 3);
          pat_i = (pat_i + 1) % 4;
        end
      end
      default: begin
        tx_ready  = 1'b1;
        pat_i     = 0;
        stall_cnt = 0;
      end
    endcase
  end

  task automatic idle(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set0(fields_t f);
    data_in = f.data; crc0_data = f.crc0; enc0_row_p = f.row0; enc0_col_p = f.col0;
  endtask

  task automatic set1(fields_t f);
    msg_len = f.len; msg_tag = f.tag; crc1_data = f.crc1; enc1_row_p = f.row1; enc1_col_p = f.col1;
  endtask

  task automatic drive0(fields_t f);
    set0(f); enc0_done = 1'b1; idle(1); enc0_done = 1'b0;
  endtask

  task automatic drive1(fields_t f);
    set1(f); enc1_done = 1'b1; idle(1); enc1_done = 1'b0;
  endtask

  task automatic drive_both(fields_t f);
    set0(f); set1(f); enc0_done = 1'b1; enc1_done = 1'b1; idle(1);
    enc0_done = 1'b0; enc1_done = 1'b0;
  endtask

  // First tx_valid exactly two cycles after the completing done.
  task automatic check_latency();
    @(negedge clk); check("lat_cycle1", 32'(tx_valid), 32'd0);
    @(negedge clk); check("lat_cycle2", 32'(tx_valid), 32'd1);
  endtask

  task automatic wait_cnt(int n);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (sent_cnt >= n) begin ok = 1'b1; break; end
    end
    check("wait_idx", 32'(ok), 32'd1);
  endtask

  task automatic wait_frame(int exp_n);
    int n = 0;
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (frame_done) begin got = 1'b1; break; end
    end
    check("frame_done_seen", 32'(got), 32'd1);
    if (exp_n > 0) check("frame_cycles", 32'(n), 32'(exp_n));
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_outs", 32'({tx_data, tx_valid, busy, frame_done, ovr_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    fields_t s1, fa, fb, fr;
    int order, gap;
    s1.data = 56'h07060504030201; s1.len = 8'h07; s1.tag = 4'hA; s1.crc1 = 4'h5;
    s1.row1 = 4'h3; s1.col1 = 4'hC; s1.crc0 = 8'h9E; s1.row0 = 8'h5A; s1.col0 = 8'hA5;

    repeat (2) @(negedge clk);
    check("reset_outs", 32'({tx_data, tx_valid, busy, frame_done, ovr_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Single frame: enc1 then enc0 three cycles later.
    rmode = 0;
    push_frame(s1);
    drive1(s1);
    @(negedge clk); check("busy_wait", 32'(busy), 32'd1);
    idle(2);
    drive0(s1);
    check_latency();
    wait_frame(14);

    // Simultaneous dones.
    push_frame(s1);
    drive_both(s1);
    check_latency();
    wait_frame(14);

    // Backpressure pattern with stall at idx 6.
    rmode = 2;
    fr = rand_fields();
    push_frame(fr);
    drive_both(fr);
    check_latency();
    wait_frame(0);
    rmode = 0;
    idle(1);

    // Overrun during SEND at idx 4.
    push_frame(s1);
    drive_both(s1);
    check_latency();
    wait_cnt(4);
    fa = s1; fa.crc0 = 8'hFF;
    drive0(fa);
    @(negedge clk); check("ovr_pulse", 32'(ovr_err), 32'd1);
    @(negedge clk); check("ovr_clear", 32'(ovr_err), 32'd0);
    wait_frame(0);

    // Overwrite while waiting for the header cluster.
    fa = s1; fa.crc0 = 8'h11;
    fb = s1; fb.crc0 = 8'h22;
    push_frame(fb);
    drive0(fa);
    idle(1);
    drive0(fb);
    idle(1);
    drive1(fb);
    check_latency();
    wait_frame(14);

    // Reset mid-frame at idx 8, then a fresh frame.
    push_frame(s1);
    drive_both(s1);
    check_latency();
    wait_cnt(8);
    do_reset();
    idle(1);
    fr = rand_fields();
    push_frame(fr);
    drive_both(fr);
    check_latency();
    wait_frame(14);

    // Random frames, random arrival order/gap, random backpressure.
    rmode = 1;
    for (int t = 0; t < 12; t++) begin
      fr = rand_fields();
      order = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      push_frame(fr);
      if (order == 0) begin
        drive_both(fr);
      end else if (order == 1) begin
        drive0(fr); idle(gap); drive1(fr);
      end else begin
        drive1(fr); idle(gap); drive0(fr);
      end
      check_latency();
      wait_frame(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
